// File: rtl/twiddle_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// twiddle_fetch_ctrl
//
// Streams a run of twiddle factors out of a pair of synchronous ROMs (real and
// imaginary, one-cycle read latency) towards the FFT butterfly over a
// valid/ready handshake. A run is "count" consecutive ROM words starting at
// "base_addr"; the address wraps modulo 2^ADDR_W. A two-entry output FIFO
// absorbs the ROM latency so the stream keeps one beat per cycle when the
// butterfly is always ready, and no word is lost when it stalls.
//
// Optional feature (compile-time macro TWIDDLE_CONJ_EN):
//   when defined, tw_im carries the negated ROM imaginary word (complex
//   conjugate, for the inverse transform); the most negative word saturates
//   to the most positive one. When undefined, tw_im is the ROM word unchanged.
//
// Parameters
//   ADDR_W      ROM address width
//   DATA_W      twiddle word width (signed Q8.8 at the default of 16)
//
// Ports
//   clk         single clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       run request, only looked at while idle
//   base_addr   first ROM address of the run (latched on accepted start)
//   count       number of words in the run, 0..2^ADDR_W (latched on start)
//   rom_addr    registered address shared by both ROMs
//   rom_re_data real ROM word, valid one cycle after rom_addr
//   rom_im_data imaginary ROM word, valid one cycle after rom_addr
//   tw_re/tw_im twiddle pair towards the butterfly
//   tw_valid    twiddle pair valid
//   tw_ready    butterfly accepts the current pair
//   tw_last     marks the final beat of the run
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse once the run has finished
// -----------------------------------------------------------------------------
module twiddle_fetch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              tw_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, state_nxt;

  // Reads still to be issued in the current run.
  logic [ADDR_W:0] remain;

  // One read may be outstanding in the ROM; its last-beat tag travels with it.
  logic in_flight;
  logic in_flight_last;

  // Two-entry output FIFO, circular with one-bit pointers.
  logic [1:0][DATA_W-1:0] fifo_re;
  logic [1:0][DATA_W-1:0] fifo_im;
  logic [1:0]             fifo_last;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             occ;

  logic              pop;
  logic              room;
  logic              issue;
  logic              accept;
  logic              done_nxt;
  logic [DATA_W-1:0] im_word;

  // Imaginary word as it will be presented to the butterfly.
`ifdef TWIDDLE_CONJ_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  assign im_word = (rom_im_data == MOST_NEG) ? ~MOST_NEG : (~rom_im_data + 1'b1);
`else
  assign im_word = rom_im_data;
`endif

  // The FIFO head drives the output directly, so the pair stays frozen while
  // the butterfly stalls.
  assign tw_valid = (occ != 2'd0);
  assign tw_re    = fifo_re[rd_ptr];
  assign tw_im    = fifo_im[rd_ptr];
  assign tw_last  = fifo_last[rd_ptr];
  assign pop      = tw_valid && tw_ready;
  assign busy     = (state != IDLE);

  // A new read is only allowed if, counting the word still in the ROM and the
  // beat leaving this cycle, the FIFO is guaranteed a free slot for it.
  assign room = (({1'b0, occ} + {2'b00, in_flight} - {2'b00, pop}) < 3'd2);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_nxt = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (remain == CNT_ONE) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && tw_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address generation, read tracking and the output FIFO. Clearing in_flight
  // on reset is what drops a ROM word that was still on its way.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr       <= '0;
      remain         <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
      fifo_re        <= '0;
      fifo_im        <= '0;
      fifo_last      <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      occ            <= 2'd0;
    end else begin
      done           <= done_nxt;
      in_flight      <= issue;
      in_flight_last <= issue && (remain == CNT_ONE);

      if (accept) begin
        rom_addr <= base_addr;
        remain   <= count;
      end else if (issue) begin
        rom_addr <= rom_addr + 1'b1;
        remain   <= remain - 1'b1;
      end

      if (in_flight) begin
        fifo_re[wr_ptr]   <= rom_re_data;
        fifo_im[wr_ptr]   <= im_word;
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      occ <= occ + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule

// File: doc/twiddle_fetch_ctrl.md
TWIDDLE_FETCH_CTRL -- requirements
Module: twiddle_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 16, twiddle word width (signed Q8.8).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1, request a fetch run; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first ROM address; latched on accepted start.
REQ-007 SHALL have port count, input, ADDR_W+1, number of entries (0..32); latched on accepted start.
REQ-008 SHALL have port rom_addr, output, ADDR_W, registered address to real/imag twiddle ROMs.
REQ-009 SHALL have port rom_re_data, input, DATA_W, real ROM output, valid one cycle after rom_addr.
REQ-010 SHALL have port rom_im_data, input, DATA_W, imag ROM output, valid one cycle after rom_addr.
REQ-011 SHALL have ports tw_re and tw_im, output, DATA_W each, twiddle pair to butterfly.
REQ-012 SHALL have port tw_valid, output, 1; port tw_ready, input, 1; port tw_last, output, 1, final beat of run.
REQ-013 SHALL have port busy, output, 1, high outside IDLE; port done, output, 1, one-cycle end-of-run pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, DRAIN.
REQ-015 IDLE: start=1 at edge N with count>0 SHALL latch base_addr/count, drive rom_addr=base_addr, enter FETCH.
REQ-016 IDLE: start=1 with count=0 SHALL leave state IDLE, emit no beats, pulse done in the cycle after edge N.
REQ-017 ROM reads SHALL be tracked with a 1-cycle in-flight flag; ROM data SHALL be written to a 2-entry output FIFO on the edge after the read.
REQ-018 A read SHALL be issued in a cycle only if FIFO occupancy + in-flight - (tw_valid&&tw_ready) < 2; otherwise rom_addr SHALL hold and no read SHALL be marked.
REQ-019 After each issued read rom_addr SHALL increment modulo 2^ADDR_W (0x1F -> 0x00 wrap).
REQ-020 FETCH -> DRAIN when count reads have been issued; rom_addr SHALL then hold.
REQ-021 DRAIN -> IDLE on the edge where the tw_last beat is accepted; done SHALL pulse the following cycle with busy low.
REQ-022 First tw_valid SHALL be high in the cycle after edge N+2; with tw_ready held high, one beat per cycle.
REQ-023 tw_valid/tw_re/tw_im/tw_last SHALL remain stable while tw_valid=1 and tw_ready=0.
REQ-024 tw_last SHALL be high only with the count-th beat.
REQ-025 start while busy SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE, rom_addr=0, tw_re=0, tw_im=0, tw_valid=0, tw_last=0, busy=0, done=0, FIFO empty, in-flight cleared.
REQ-027 A ROM read outstanding at reset SHALL be discarded, never written to the FIFO.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro TWIDDLE_CONJ_EN defined, tw_im SHALL be the two's-complement negation of the ROM imag word (0x8000 saturates to 0x7FFF), for inverse transform.
REQ-030 Without TWIDDLE_CONJ_EN, tw_im SHALL equal the ROM imag word unchanged.

Verification
REQ-031 Bench ROM real model: addr 0x00->0x0100, 0x09->0x00B5, 0x0B->0xFF4A; start base=0x08 count=4, tw_ready=1 -> beats re 0x0100,0x00B5,0x0000,0xFF4A, tw_last on 4th, done one cycle later.
REQ-032 base=0x1E count=4 -> rom_addr sequence 0x1E,0x1F,0x00,0x01; four beats, no gaps with tw_ready=1.
REQ-033 tw_ready toggled 1,0,0,1,... over a count=8 run -> exactly 8 beats, none lost or duplicated, outputs stable while stalled.
REQ-034 count=0 start -> no tw_valid, done pulse one cycle after start, busy stays 0.
REQ-035 rst asserted mid-FETCH with read in flight -> all outputs 0 next cycle; subsequent run base=0x00 count=2 yields exactly beats 0x0100,0x0100.
REQ-036 TWIDDLE_CONJ_EN defined, ROM imag 0x004A -> tw_im 0xFFB6; imag 0x8000 -> tw_im 0x7FFF.
